// File: rtl/pulse_timer_pkg.sv
// pulse_timer shared types
// FSM state encoding for the pulse generator
package pulse_timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/pt_down_counter.sv
// pt_down_counter: loadable down counter
// Load wins over decrement; zero flag is combinational
module pt_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // count register: load has priority over decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_timer.sv
// pulse_timer: programmable delay + pulse train
// FSM, config latch and completed-pulse count
module pulse_timer
  import pulse_timer_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_HIGH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             retrig,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_len,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  if (DEF_HIGH < 1 || DEF_HIGH > (1 << CNT_W) - 1) begin : g_def_high_chk
    $error("DEF_HIGH does not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cfg_h;
  logic [CNT_W-1:0] cfg_l;
  logic [CNT_W-1:0] cfg_r;
  logic [CNT_W-1:0] high_eff;
  logic [CNT_W-1:0] low_eff;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             start;
  logic             restart;
  logic             accept;
  logic             last_pulse;

  assign high_eff = (high_len == '0) ? DEF_H : high_len;
  assign low_eff  = (low_len == '0) ? ONE : low_len;

  assign start   = en && !abort && (state == ST_IDLE);
  assign restart = en && retrig && !abort
                && (state != ST_IDLE);
  assign accept  = start || restart;

  // pulse_cnt starts at 0, so pulse R is the one that makes it R
  assign last_pulse = (cfg_r != '0)
                   && ((pulse_cnt + ONE) == cfg_r);

  // counter control derived from the same decisions as the FSM
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = delay_len;
    if (abort) begin
      cnt_load = 1'b0;
    end else if (accept) begin
      cnt_load = 1'b1;
      cnt_val  = delay_len;
    end else begin
      unique case (state)
        ST_DELAY, ST_LOW: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = cfg_h - ONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_zero) begin
            if (!last_pulse) begin
              cnt_load = 1'b1;
              cnt_val  = cfg_l - ONE;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          cnt_load = 1'b0;
        end
      endcase
    end
  end

  pt_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // sequencing FSM with registered outputs: abort > retrigger > normal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      cfg_h     <= '0;
      cfg_l     <= '0;
      cfg_r     <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        dout  <= 1'b0;
        busy  <= 1'b0;
      end else if (accept) begin
        cfg_h     <= high_eff;
        cfg_l     <= low_eff;
        cfg_r     <= rep_cnt;
        pulse_cnt <= '0;
        dout      <= 1'b0;
        busy      <= 1'b1;
        state     <= ST_DELAY;
      end else begin
        unique case (state)
          ST_DELAY, ST_LOW: begin
            if (cnt_zero) begin
              state <= ST_HIGH;
              dout  <= 1'b1;
            end
          end
          ST_HIGH: begin
            if (cnt_zero) begin
              pulse_cnt <= pulse_cnt + ONE;
              dout      <= 1'b0;
              if (last_pulse) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_LOW;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_timer.sv
// tb_pulse_timer: directed scoreboard bench
// Expected per-edge outputs are queued by stimulus, checked by a monitor
module tb_pulse_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       retrig = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] delay_len = '0;
  logic [7:0] high_len = '0;
  logic [7:0] low_len = '0;
  logic [7:0] rep_cnt = '0;
  logic       dout;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  typedef struct {
    int         e;
    logic       dout;
    logic       busy;
    logic       done;
    logic [7:0] pc;
  } exp_t;

  exp_t q[$];
  int   ecnt = 0;
  int   checks = 0;
  int   errors = 0;

  pulse_timer #(
    .CNT_W    (8),
    .DEF_HIGH (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .retrig    (retrig),
    .abort     (abort),
    .delay_len (delay_len),
    .high_len  (high_len),
    .low_len   (low_len),
    .rep_cnt   (rep_cnt),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    exp_t x;
    while (q.size() > 0 && q[0].e < ecnt) begin
      x = q.pop_front();
      errors++;
      $display("FAIL missed edge=%0d expected sample not taken", x.e);
    end
    if (q.size() > 0 && q[0].e == ecnt) begin
      x = q.pop_front();
      checks++;
      if (dout !== x.dout || busy !== x.busy || done !== x.done
          || pulse_cnt !== x.pc || (dout && done)) begin
        errors++;
        $display("FAIL edge=%0d got dout=%b busy=%b done=%b pc=%0d want dout=%b busy=%b done=%b pc=%0d",
                 x.e, dout, busy, done, pulse_cnt,
                 x.dout, x.busy, x.done, x.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int e, input logic d, input logic b,
                           input logic dn, input int pc);
    exp_t x;
    x.e    = e;
    x.dout = d;
    x.busy = b;
    x.done = dn;
    x.pc   = 8'(pc);
    q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    for (int k = 1; k <= 3; k++) expect_at(k, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // default high length, single pulse
    delay_len = 0; high_len = 0; low_len = 0; rep_cnt = 1;
    en = 1'b1;
    e0 = ecnt + 1;
    expect_at(e0, 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) expect_at(e0 + k, 1, 1, 0, 0);
    expect_at(e0 + 11, 0, 0, 1, 1);
    expect_at(e0 + 12, 0, 0, 0, 1);
    step();
    en = 1'b0;
    repeat (12) step();

    // delay 2, two pulses of 3 with gap 1; config changed after trigger
    delay_len = 2; high_len = 3; low_len = 1; rep_cnt = 2;
    en = 1'b1;
    e0 = ecnt + 1;
    for (int k = 0; k <= 11; k++)
      expect_at(e0 + k,
                (k >= 3 && k <= 5) || (k >= 7 && k <= 9),
                k < 10, k == 10,
                k >= 10 ? 2 : (k >= 6 ? 1 : 0));
    step();
    en = 1'b0;
    delay_len = 9; high_len = 7; low_len = 5; rep_cnt = 4;
    repeat (11) step();

    // continuous mode, period 4, count wraps, then abort
    delay_len = 0; high_len = 2; low_len = 2; rep_cnt = 0;
    en = 1'b1;
    e0 = ecnt + 1;
    for (int k = 0; k <= 1040; k++)
      expect_at(e0 + k, k >= 1 && ((k - 1) % 4 < 2), 1, 0,
                ((k + 1) / 4) % 256);
    expect_at(e0 + 1041, 0, 0, 0, 4);
    expect_at(e0 + 1042, 0, 0, 0, 4);
    step();
    en = 1'b0;
    repeat (1040) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // retrigger during third high cycle
    delay_len = 1; high_len = 5; low_len = 1; rep_cnt = 1;
    retrig = 1'b1;
    en = 1'b1;
    e0 = ecnt + 1;
    for (int k = 0; k <= 13; k++)
      expect_at(e0 + k,
                (k >= 2 && k <= 4) || (k >= 7 && k <= 11),
                k < 12, k == 12, k >= 12 ? 1 : 0);
    step();
    en = 1'b0;
    repeat (4) step();
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (8) step();
    retrig = 1'b0;

    // en held with retrig=0: back-to-back with one idle cycle
    delay_len = 0; high_len = 4; low_len = 1; rep_cnt = 1;
    en = 1'b1;
    e0 = ecnt + 1;
    for (int k = 0; k <= 12; k++)
      expect_at(e0 + k,
                (k >= 1 && k <= 4) || (k >= 7 && k <= 10),
                !(k == 5 || k >= 11), k == 5 || k == 11,
                k <= 4 ? 0 : (k == 5 ? 1 : (k <= 10 ? 0 : 1)));
    repeat (12) step();
    en = 1'b0;
    step();

    // async reset in the middle of the second high pulse
    delay_len = 0; high_len = 2; low_len = 1; rep_cnt = 3;
    en = 1'b1;
    e0 = ecnt + 1;
    expect_at(e0, 0, 1, 0, 0);
    expect_at(e0 + 1, 1, 1, 0, 0);
    expect_at(e0 + 2, 1, 1, 0, 0);
    expect_at(e0 + 3, 0, 1, 0, 1);
    expect_at(e0 + 4, 0, 0, 0, 0);
    expect_at(e0 + 5, 0, 0, 0, 0);
    step();
    en = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // abort together with en in idle: no start
    abort = 1'b1;
    en = 1'b1;
    expect_at(ecnt + 1, 0, 0, 0, 0);
    expect_at(ecnt + 2, 0, 0, 0, 0);
    step();
    abort = 1'b0;
    en = 1'b0;
    step();

    repeat (3) step();
    if (q.size() != 0) begin
      $display("FAIL leftover got=%0d pending want=0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
